// File: rtl/switch_debounce_2ch.sv
// Two-channel switch conditioner: 2-flop synchronizer, counter-based debounce FSM
// and registered rise/fall pulses per channel. Channels share no state.

module debounceChannel #(
    parameter int CNT_MAX = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iSw,
    output logic oLevel,
    output logic oRise,
    output logic oFall
);

    typedef enum logic [1:0] {
        STABLE0,
        WAIT1,
        STABLE1,
        WAIT0
    } stateT;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

    logic [1:0]       syncFf;
    logic             sync;
    stateT            state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             levelNext, riseNext, fallNext;

    assign sync = syncFf[1];

    // NOTE: every flop, synchronizer included, clears asynchronously so no partial count survives reset.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            syncFf <= '0;
            state  <= STABLE0;
            cnt    <= '0;
            oLevel <= 1'b0;
            oRise  <= 1'b0;
            oFall  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            syncFf <= {syncFf[0], iSw};
            state  <= stateNext;
            cnt    <= cntNext;
            oLevel <= levelNext;
            oRise  <= riseNext;
            oFall  <= fallNext;
        end
    end

    // NOTE: defaults first so no path through the case can infer a latch.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        levelNext = oLevel;
        riseNext  = 1'b0;
        fallNext  = 1'b0;
        case (state)
            STABLE0: begin
                if (sync) begin
                    stateNext = WAIT1;
                    cntNext   = '0;
                end
            end
            WAIT1: begin
                if (!sync) begin
                    stateNext = STABLE0;
                end else if (cnt == CntLast) begin
                    stateNext = STABLE1;
                    levelNext = 1'b1;
                    riseNext  = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            STABLE1: begin
                if (!sync) begin
                    stateNext = WAIT0;
                    cntNext   = '0;
                end
            end
            WAIT0: begin
                if (sync) begin
                    stateNext = STABLE1;
                end else if (cnt == CntLast) begin
                    stateNext = STABLE0;
                    levelNext = 1'b0;
                    fallNext  = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: stateNext = STABLE0;
        endcase
    end

endmodule

module switch_debounce_2ch #(
    parameter int CNT_MAX = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iSwA,
    input  logic iSwB,
    output logic oA,
    output logic oB,
    output logic oARise,
    output logic oAFall,
    output logic oBRise,
    output logic oBFall
);

    debounceChannel #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) uChA (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iSw    (iSwA),
        .oLevel (oA),
        .oRise  (oARise),
        .oFall  (oAFall)
    );

    debounceChannel #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) uChB (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iSw    (iSwB),
        .oLevel (oB),
        .oRise  (oBRise),
        .oFall  (oBFall)
    );

endmodule

// File: tb/tb_switch_debounce_2ch.sv
// Bench for switch_debounce_2ch: segment table with end-of-segment levels, a per-cycle
// scoreboard fed by a run-length reference model, and hand-timed reset/latency sequences.

module tb_switch_debounce_2ch;

    localparam int CNT_MAX = 4;
    localparam int CNT_W   = 3;

    logic iClk = 1'b0;
    logic iRst_n, iSwA, iSwB;
    logic oA, oB, oARise, oAFall, oBRise, oBFall;

    switch_debounce_2ch #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iSwA   (iSwA),
        .iSwB   (iSwB),
        .oA     (oA),
        .oB     (oB),
        .oARise (oARise),
        .oAFall (oAFall),
        .oBRise (oBRise),
        .oBFall (oBFall)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic a;
        logic b;
        logic aRise;
        logic aFall;
        logic bRise;
        logic bFall;
    } outsT;

    typedef struct {
        logic swA;
        logic swB;
        int   len;
        logic expA;
        logic expB;
    } vecT;

    outsT sbQ[$];
    logic mdlD[2];
    int   mdlRun[2];
    int   errors = 0;
    int   checks = 0;

    function automatic outsT dutOuts();
        return {oA, oB, oARise, oAFall, oBRise, oBFall};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The level flips once the raw input has differed from it for CNT_MAX+1
    // consecutive samples; the two-flop synchronizer delays the visible result by 2 edges.
    task automatic modelReset();
        mdlD[0]   = 1'b0;
        mdlD[1]   = 1'b0;
        mdlRun[0] = 0;
        mdlRun[1] = 0;
        sbQ.delete();
        sbQ.push_back('0);
        sbQ.push_back('0);
    endtask

    task automatic step(input logic a, input logic b);
        logic raw[2];
        logic rs[2];
        logic fl[2];
        outsT e;
        outsT got;
        iSwA   = a;
        iSwB   = b;
        raw[0] = a;
        raw[1] = b;
        for (int ch = 0; ch < 2; ch++) begin
            rs[ch] = 1'b0;
            fl[ch] = 1'b0;
            if (raw[ch] !== mdlD[ch]) begin
                mdlRun[ch]++;
                if (mdlRun[ch] == CNT_MAX + 1) begin
                    mdlD[ch]   = raw[ch];
                    mdlRun[ch] = 0;
                    rs[ch]     = raw[ch];
                    fl[ch]     = ~raw[ch];
                end
            end else begin
                mdlRun[ch] = 0;
            end
        end
        e = {mdlD[0], mdlD[1], rs[0], fl[0], rs[1], fl[1]};
        sbQ.push_back(e);
        @(posedge iClk);
        #1;
        got = dutOuts();
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no entry expected one at %0t", $time);
        end else begin
            check("scoreboard", {2'b00, got}, {2'b00, sbQ.pop_front()});
        end
    endtask

    // Drives one level for up to 10 edges; reports the edge index where oA first rose.
    task automatic measureRiseA(input logic b, output int firstIdx, output int nRise);
        firstIdx = -1;
        nRise    = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, b);
            if (oARise) nRise++;
            if (oA && firstIdx < 0) firstIdx = k;
        end
    endtask

    vecT vecs[17];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int firstIdx;
        int nRise;

        vecs[0]  = '{0, 0, 20, 0, 0};  // idle after reset
        vecs[1]  = '{1, 0, 10, 1, 0};  // clean press A
        vecs[2]  = '{0, 0, 10, 0, 0};  // clean release A
        vecs[3]  = '{1, 0,  3, 0, 0};  // bounce: 3 high
        vecs[4]  = '{0, 0,  2, 0, 0};  //         2 low
        vecs[5]  = '{1, 0,  3, 0, 0};  //         3 high
        vecs[6]  = '{0, 0, 10, 0, 0};  //         then low
        vecs[7]  = '{1, 0,  4, 0, 0};  // one sample short of acceptance
        vecs[8]  = '{0, 0,  8, 0, 0};
        vecs[9]  = '{1, 0,  5, 0, 0};  // exactly enough samples
        vecs[10] = '{0, 0,  3, 1, 0};  // rise lands after the input already fell
        vecs[11] = '{0, 0, 10, 0, 0};
        vecs[12] = '{1, 1, 10, 1, 1};  // simultaneous press
        vecs[13] = '{1, 0,  2, 1, 1};  // 2-cycle glitch on B
        vecs[14] = '{1, 1, 10, 1, 1};
        vecs[15] = '{0, 1, 10, 0, 1};  // release A only
        vecs[16] = '{0, 0, 10, 0, 0};

        iRst_n = 1'b1;
        iSwA   = 1'b0;
        iSwB   = 1'b0;
        #2;
        iRst_n = 1'b0;
        #1;
        check("reset_async", {2'b00, dutOuts()}, 8'h00);
        repeat (3) @(posedge iClk);
        #1;
        check("reset_hold", {2'b00, dutOuts()}, 8'h00);
        @(negedge iClk);
        iRst_n = 1'b1;
        modelReset();

        for (int i = 0; i < 17; i++) begin
            for (int c = 0; c < vecs[i].len; c++) step(vecs[i].swA, vecs[i].swB);
            check($sformatf("seg%0d_oA", i), {7'd0, oA}, {7'd0, vecs[i].expA});
            check($sformatf("seg%0d_oB", i), {7'd0, oB}, {7'd0, vecs[i].expB});
        end

        // Exact press latency: oA and oARise first appear 6 edges after the sampled edge.
        measureRiseA(1'b0, firstIdx, nRise);
        check("press_latency", 8'(firstIdx), 8'd6);
        check("press_rise_count", 8'(nRise), 8'd1);

        // Asynchronous reset while oA is high clears it before any clock edge.
        @(posedge iClk);
        #3;
        iRst_n = 1'b0;
        #1;
        check("reset_clears_high", {2'b00, dutOuts()}, 8'h00);
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        modelReset();

        // Released with A held high: full debounce from STABLE0.
        measureRiseA(1'b0, firstIdx, nRise);
        check("release_high_latency", 8'(firstIdx), 8'd6);
        check("release_high_rise_count", 8'(nRise), 8'd1);

        // Reset mid-count: A falls back to 0 path first, then re-press to WAIT1 with count 2.
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        #3;
        iRst_n = 1'b0;
        #1;
        check("midcount_reset", {2'b00, dutOuts()}, 8'h00);
        repeat (2) @(posedge iClk);
        #1;
        check("midcount_reset_hold", {2'b00, dutOuts()}, 8'h00);
        @(negedge iClk);
        iRst_n = 1'b1;
        modelReset();
        measureRiseA(1'b0, firstIdx, nRise);
        check("recount_latency", 8'(firstIdx), 8'd6);
        check("recount_rise_count", 8'(nRise), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
